// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one pipelined ZBT SRAM between two requesters.
// Port 0 is the CPU, port 1 is the loader/DMA. At most one access is accepted per cycle.
// SRAM address and control pins come straight from registers.
// A 3-stage tag pipeline decides when ZD is driven (writes) and when it is captured (reads).
// Optional build macro: SRAM_ARB_RR_EN selects round-robin arbitration.
// Without it, port 0 always has fixed priority over port 1.
module sram_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W/8-1:0]   be0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_W-1:0]     rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [DATA_W/8-1:0]   be1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_W-1:0]     rdata1,
    inout  wire  [DATA_W-1:0]     ZD,
    output logic [ADDR_W-1:0]     ZA,
    output logic                  XE1,
    output logic                  XWA,
    output logic [DATA_W/8-1:0]   XZBE
);
    localparam int BE_W   = DATA_W / 8;
    localparam int STAGES = 3;

    typedef struct packed {
        logic              valid;
        logic              port;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } tag_t;

    logic              sel1;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;

`ifdef SRAM_ARB_RR_EN
    // last_q remembers the last granted port.
    // Its reset value of 1 makes port 0 win the first conflict.
    logic last_q, last_d;

    // Update the pointer only when something is granted
    always_comb begin
        last_d = last_q;
        if (accept) last_d = sel1;
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end
`endif

    // Pick one requester; reset suppresses both grants
    always_comb begin
`ifdef SRAM_ARB_RR_EN
        sel1 = req1 & (~req0 | ~last_q);
`else
        sel1 = req1 & ~req0;
`endif
        gnt0      = ~reset & req0 & ~sel1;
        gnt1      = ~reset & sel1;
        accept    = gnt0 | gnt1;
        sel_we    = sel1 ? we1    : we0;
        sel_addr  = sel1 ? addr1  : addr0;
        sel_wdata = sel1 ? wdata1 : wdata0;
        sel_be    = sel1 ? be1    : be0;
    end

    logic [ADDR_W-1:0] za_q, za_d;
    logic              xe1_q, xe1_d;
    logic              xwa_q, xwa_d;
    logic [BE_W-1:0]   xzbe_q, xzbe_d;

    // Next SRAM address/control.
    // When idle, the chip is deselected and ZA holds its value.
    always_comb begin
        za_d   = za_q;
        xe1_d  = 1'b1;
        xwa_d  = 1'b1;
        xzbe_d = '1;
        if (accept) begin
            za_d   = sel_addr;
            xe1_d  = 1'b0;
            xwa_d  = ~sel_we;
            xzbe_d = sel_we ? ~sel_be : '0;
        end
    end

    // SRAM address/control pin registers
    always_ff @(posedge clk) begin
        if (reset) begin
            za_q   <= '0;
            xe1_q  <= 1'b1;
            xwa_q  <= 1'b1;
            xzbe_q <= '1;
        end else begin
            za_q   <= za_d;
            xe1_q  <= xe1_d;
            xwa_q  <= xwa_d;
            xzbe_q <= xzbe_d;
        end
    end

    assign ZA   = za_q;
    assign XE1  = xe1_q;
    assign XWA  = xwa_q;
    assign XZBE = xzbe_q;

    tag_t tag_q [STAGES];
    tag_t tag_d [STAGES];

    // Tag pipeline: stage 0 loads at accept, later stages shift every cycle
    always_comb begin
        tag_d[0].valid = accept;
        tag_d[0].port  = sel1;
        tag_d[0].we    = sel_we;
        tag_d[0].wdata = sel_wdata;
        for (int i = 1; i < STAGES; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Tag pipeline registers; reset drops every in-flight access
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (reset) tag_q[i] <= '0;
            else       tag_q[i] <= tag_d[i];
        end
    end

    // Last stage is the SRAM data phase.
    // A write drives ZD from a register here; otherwise ZD is released.
    logic zd_oe;
    assign zd_oe = tag_q[STAGES-1].valid & tag_q[STAGES-1].we;
    assign ZD    = zd_oe ? tag_q[STAGES-1].wdata : {DATA_W{1'bz}};

    logic [1:0]        rvalid_vec;
    logic [DATA_W-1:0] rdata_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic              rvalid_q, rvalid_d;
            logic [DATA_W-1:0] rdata_q, rdata_d;

            // Capture ZD for a read that belongs to this port; otherwise hold the data
            always_comb begin
                rvalid_d = tag_q[STAGES-1].valid & ~tag_q[STAGES-1].we
                           & (tag_q[STAGES-1].port == 1'(gi));
                rdata_d  = rvalid_d ? ZD : rdata_q;
            end

            // Read return registers
            always_ff @(posedge clk) begin
                if (reset) begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                end else begin
                    rvalid_q <= rvalid_d;
                    rdata_q  <= rdata_d;
                end
            end

            assign rvalid_vec[gi] = rvalid_q;
            assign rdata_arr[gi]  = rdata_q;
        end
    endgenerate

    assign rvalid0 = rvalid_vec[0];
    assign rvalid1 = rvalid_vec[1];
    assign rdata0  = rdata_arr[0];
    assign rdata1  = rdata_arr[1];
endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter.
// It models a pipelined ZBT SRAM: the address is sampled one edge after the arbiter drives it.
// Data moves on the bus in the cycle after the next edge.
// Expected read responses go into per-port queues.
// A negedge monitor pops an entry and compares it whenever rvalid is asserted.
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [19:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  be0, be1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    wire  [31:0] ZD;
    logic [19:0] ZA;
    logic        XE1, XWA;
    logic [3:0]  XZBE;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(20), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .be0(be0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .be1(be1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ZD(ZD), .ZA(ZA), .XE1(XE1), .XWA(XWA), .XZBE(XZBE)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- fake ZBT SRAM ----------------
    logic [31:0] mem [int unsigned];
    typedef struct packed { logic v; logic we; logic [19:0] a; logic [3:0] nbe; } acc_t;
    acc_t p1 = '0, p2 = '0;
    logic        m_oe = 1'b0;
    logic [31:0] m_dq = '0;
    assign ZD = m_oe ? m_dq : 32'bz;

    always @(posedge clk) begin
        logic [31:0] w;
        // write data phase (bus cycle just ending)
        if (p2.v && p2.we) begin
            w = mem.exists(p2.a) ? mem[p2.a] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (!p2.nbe[b]) w[b*8 +: 8] = ZD[b*8 +: 8];
            mem[p2.a] = w;
        end
        // read data phase for the next cycle
        m_oe <= p1.v && !p1.we;
        m_dq <= (p1.v && !p1.we && mem.exists(p1.a)) ? mem[p1.a] : 32'h0;
        p2 <= p1;
        p1 <= '{v: !XE1, we: !XWA, a: ZA, nbe: XZBE};
    end

    // ---------------- checking ----------------
    int total = 0, passed = 0;
    function automatic void chk(string name, bit ok, logic [63:0] act, logic [63:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    endfunction

    typedef struct { logic [31:0] data; int at; } exp_t;
    exp_t q0[$], q1[$];

    function automatic void push_exp(int port, logic [31:0] d, int at);
        exp_t e;
        e.data = d; e.at = at;
        if (port == 0) q0.push_back(e); else q1.push_back(e);
    endfunction

    // Monitor: every rvalid must match the oldest expected response for that port
    always @(negedge clk) begin
        exp_t e;
        if (rvalid0) begin
            if (q0.size() == 0) chk("rvalid0_unexpected", 1'b0, 1, 0);
            else begin
                e = q0.pop_front();
                chk("rdata0", rdata0 == e.data, rdata0, e.data);
                chk("rvalid0_cycle", cyc == e.at, cyc, e.at);
                $display("port0 read data 0x%08h at cycle %0d", rdata0, cyc);
            end
        end
        if (rvalid1) begin
            if (q1.size() == 0) chk("rvalid1_unexpected", 1'b0, 1, 0);
            else begin
                e = q1.pop_front();
                chk("rdata1", rdata1 == e.data, rdata1, e.data);
                chk("rvalid1_cycle", cyc == e.at, cyc, e.at);
                $display("port1 read data 0x%08h at cycle %0d", rdata1, cyc);
            end
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Called 1 time unit after a posedge.
    // Holds the request until it is granted, then returns at posedge+1 of A+1.
    task automatic issue(input int port, input logic we, input logic [19:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] exp_rd, input bit push, output int acc);
        bit got;
        if (port == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; be0 = be; end
        else           begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; be1 = be; end
        #1;
        got = 0;
        acc = -1;
        for (int t = 0; t < 20 && !got; t++) begin
            if ((port == 0) ? gnt0 : gnt1) got = 1;
            else begin @(posedge clk); #2; end
        end
        chk("gnt_seen", got, 0, 1);
        if (got) begin
            acc = cyc;
            chk("other_gnt_low", ((port == 0) ? gnt1 : gnt0) == 1'b0, 1, 0);
            $display("port%0d %s addr 0x%05h data 0x%08h granted in cycle %0d",
                     port, we ? "write" : "read", a, wd, acc);
            if (push && !we) push_exp(port, exp_rd, acc + 4);
        end
        @(posedge clk); #1;
        if (port == 0) req0 = 0; else req1 = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    int a, a1, a2;
    bit exp0;

    initial begin
        mem[32'h10] = 32'hDEADBEEF;
        mem[32'h20] = 32'hAAAAAAAA;
        for (int i = 0; i < 4; i++) begin
            mem[32'h100 + i] = 32'h1111_0000 | i;
            mem[32'h200 + i] = 32'h2222_0000 | i;
        end
        reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; be0 = 0; be1 = 0;

        // Reset state, with a request held to show reset wins
        repeat (2) @(posedge clk);
        #1 req0 = 1; addr0 = 20'h5;
        @(negedge clk);
        chk("rst_gnt0", gnt0 == 1'b0, gnt0, 0);
        chk("rst_xe1", XE1 == 1'b1, XE1, 1);
        chk("rst_xwa", XWA == 1'b1, XWA, 1);
        chk("rst_xzbe", XZBE == 4'hF, XZBE, 4'hF);
        chk("rst_za", ZA == 20'h0, ZA, 0);
        chk("rst_rvalid", {rvalid0, rvalid1} == 2'b00, {rvalid0, rvalid1}, 0);
        chk("rst_rdata", {rdata0, rdata1} == 64'h0, {rdata0, rdata1}, 0);
        @(posedge clk); #1 reset = 0; req0 = 0;

        // Contention: both ports request reads for 4 cycles
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 20'h100; addr1 = 20'h200;
        a1 = 0; a2 = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
`ifdef SRAM_ARB_RR_EN
            exp0 = (k % 2 == 0);
`else
            exp0 = 1'b1;
`endif
            chk("cont_gnt0", gnt0 == exp0, gnt0, exp0);
            chk("cont_gnt1", gnt1 == !exp0, gnt1, !exp0);
            $display("contention cycle %0d gnt0=%0b gnt1=%0b", k, gnt0, gnt1);
            if (gnt0) begin push_exp(0, 32'h1111_0000 | a1, cyc + 4); a1++; end
            if (gnt1) begin push_exp(1, 32'h2222_0000 | a2, cyc + 4); a2++; end
            @(posedge clk); #1;
            addr0 = 20'h100 + 20'(a1);
            addr1 = 20'h200 + 20'(a2);
        end
        req0 = 0; req1 = 0;
        repeat (6) sync();

        // Simple port 0 read
        issue(0, 0, 20'h10, 0, 0, 32'hDEADBEEF, 1, a);
        @(negedge clk);
        chk("rd_za", ZA == 20'h10, ZA, 20'h10);
        chk("rd_xe1", XE1 == 1'b0, XE1, 0);
        chk("rd_xwa", XWA == 1'b1, XWA, 1);
        chk("rd_xzbe", XZBE == 4'h0, XZBE, 0);
        repeat (5) sync();

        // Port 1 partial write, then read back
        issue(1, 1, 20'h20, 32'h12345678, 4'b0011, 0, 0, a);
        @(negedge clk);
        chk("wr_xzbe", XZBE == 4'b1100, XZBE, 4'b1100);
        chk("wr_xwa", XWA == 1'b0, XWA, 0);
        chk("wr_za", ZA == 20'h20, ZA, 20'h20);
        @(negedge clk);
        chk("wr_zd_early", ZD !== 32'h12345678, ZD, 32'h0);
        @(negedge clk);
        chk("wr_zd_phase", ZD === 32'h12345678, ZD, 32'h12345678);
        @(negedge clk);
        chk("wr_zd_late", ZD !== 32'h12345678, ZD, 32'h0);
        sync();
        issue(1, 0, 20'h20, 0, 0, 32'hAAAA5678, 1, a);
        repeat (5) sync();

        // Back-to-back write then read of the same word
        issue(0, 1, 20'h30, 32'h1, 4'hF, 0, 0, a1);
        issue(0, 0, 20'h30, 0, 0, 32'h00000001, 1, a2);
        chk("b2b_consecutive", a2 == a1 + 1, a2, a1 + 1);
        repeat (6) sync();

        // Reset two cycles after a read is accepted
        issue(0, 0, 20'h10, 0, 0, 0, 0, a);
        sync();
        reset = 1; req0 = 1; addr0 = 20'h40;
        #1 chk("rst_mid_gnt0", gnt0 == 1'b0, gnt0, 0);
        @(posedge clk); #1 reset = 0; req0 = 0;
        @(negedge clk);
        chk("rst_mid_xe1", XE1 == 1'b1, XE1, 1);
        chk("rst_mid_xwa", XWA == 1'b1, XWA, 1);
        chk("rst_mid_xzbe", XZBE == 4'hF, XZBE, 4'hF);
        chk("rst_mid_za", ZA == 20'h0, ZA, 0);
        chk("rst_mid_rvalid0", rvalid0 == 1'b0, rvalid0, 0);
        repeat (4) sync();
        issue(0, 0, 20'h10, 0, 0, 32'hDEADBEEF, 1, a);

        repeat (8) sync();
        chk("q0_drained", q0.size() == 0, q0.size(), 0);
        chk("q1_drained", q1.size() == 0, q1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single pipelined ZBT SRAM (ZD/ZA/XE1/XWA/XZBE pins) between two requesters: port 0 (CPU load/store) and port 1 (RS-232 program loader / I/O DMA).
- Accepts at most one access per cycle. Drives the SRAM address/control pins from registers and tracks in-flight accesses in a fixed-length tag pipeline.
- Places write data on ZD, and returns read data to the correct port with a fixed latency.
- Sits in top between mips/loader and the SRAM pins. The remaining SRAM pins (E2A, XE3, XGA, XZCKE, ADVA, XFT, XLBO, ZZA, ZCLKMA) are tied off in top.

Parameters:
- ADDR_W, 20, SRAM word address width (ZA)
- DATA_W, 32, data width (ZD); byte enables are DATA_W/8 wide

Ports:
- clk  in  1  system clock; single clock domain (also SRAM clock)
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 request; held until gnt0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  ADDR_W  port 0 word address
- wdata0  in  DATA_W  port 0 write data
- be0  in  DATA_W/8  port 0 byte enables, active-high, writes only
- gnt0  out  1  port 0 request accepted this cycle
- rvalid0  out  1  port 0 read data valid, 1-cycle pulse
- rdata0  out  DATA_W  port 0 read data
- req1, we1, addr1, wdata1, be1, gnt1, rvalid1, rdata1: same set for port 1
- ZD  inout  DATA_W  SRAM data bus
- ZA  out  ADDR_W  SRAM address
- XE1  out  1  SRAM chip enable, active-low
- XWA  out  1  SRAM write enable, active-low
- XZBE  out  DATA_W/8  SRAM byte enables, active-low

Behaviour:
- Cycle A (accept): arbiter selects one asserted request. gnt for that port is high combinationally in A; the other gnt is low. Requester may change req/addr/data in A+1.
- Edge ending A: ZA<=addr, XE1<=0, XWA<=~we, XZBE<=~be for writes, 0 for reads. Address phase is cycle A+1.
- No accept in a cycle: next cycle XE1=1 and XWA=1; ZA holds its previous value.
- Tag pipeline: 3 stages, each holding {valid, port, we, wdata}. Stage 1 is loaded at accept and advances every cycle, with no stalls.
- Write: ZD is driven with wdata during cycle A+3 only, i.e. two SRAM edges after the address edge. Otherwise ZD is high-Z.
- Read: ZD is sampled at the edge ending A+3. rdataN/rvalidN are registered and valid in A+4, so the gnt-to-rvalid latency is 4 cycles. rdata of the non-selected port holds its value.
- Throughput: one access per cycle with any read/write mix. No turnaround cycles are needed (ZBT).
- Ordering: a read following a write to the same address returns the new data. No forwarding logic is needed, because SRAM ordering holds.
- Both requests high (default): port 0 wins every time. Port 1 is granted only when req0=0.
- Reset, including mid-operation:
  - All tag valids are cleared; no rvalid is issued for in-flight reads.
  - ZD is released; XE1=1, XWA=1, XZBE=all-1, ZA=0.
  - gnt0/1=0, rvalid0/1=0, rdata0/1=0.
  - The round-robin pointer resets to "port 0 preferred".
  - Reset has priority over any request in the same cycle.

Optional Feature:
- SRAM_ARB_RR_EN defined: round-robin arbitration. A 1-bit pointer records the last granted port.
  - On a conflict, the port not granted last wins.
  - The pointer updates only on a grant.
  - Uncontested requests are granted immediately.
- SRAM_ARB_RR_EN undefined: fixed priority, port 0 over port 1. No pointer register exists.

Test Plan:
- Fake SRAM word 0x00010 preloaded with 0xDEADBEEF; req0 read 0x00010 at cycle A -> gnt0 in A; ZA=0x00010, XE1=0, XWA=1 in A+1; rvalid0=1 and rdata0=0xDEADBEEF in A+4; rvalid1 stays 0.
- Port 1 write 0x12345678 to 0x00020 with be1=4'b0011, word previously 0xAAAAAAAA; then port 1 read of 0x00020 -> XZBE=4'b1100 during the write; ZD driven only in A+3; read returns 0xAAAA5678.
- Back-to-back: port 0 issues write 0x1 to 0x00030 in cycle A, then read 0x00030 in A+1 -> both granted consecutively; rvalid0 in A+5 with rdata0=0x00000001.
- req0 and req1 both held for 4 cycles, each with a new address after every gnt -> without SRAM_ARB_RR_EN: gnt0 in all 4 cycles, gnt1 never; with SRAM_ARB_RR_EN: grants alternate 0,1,0,1.
- reset asserted in A+2 after a port 0 read accepted in A -> no rvalid0 in A+4; the cycle after reset shows XE1=1, XWA=1, ZD high-Z; a new read issued after reset returns correct data 4 cycles after its gnt.
